// File: rtl/gpio_ctrl.sv
// Memory-mapped 32-bit GPIO peripheral: output/direction registers, input synchroniser,
// sticky rising-edge flags (write-1-to-clear) and a level interrupt.
module gpio_ctrl #(
    parameter int WIDTH       = 32,
    parameter int SYNC_STAGES = 2
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_clk_en,
    input  logic [2:0]       i_addr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_we,
    input  logic             i_re,
    output logic [WIDTH-1:0] o_rdata,
    output logic             o_ack,
    input  logic [WIDTH-1:0] i_gpio,
    output logic [WIDTH-1:0] o_gpio,
    output logic [WIDTH-1:0] o_gpio_oe,
    output logic             o_irq
);

    localparam logic [2:0] ADDR_OUT    = 3'd0;
    localparam logic [2:0] ADDR_DIR    = 3'd1;
    localparam logic [2:0] ADDR_IN     = 3'd2;
    localparam logic [2:0] ADDR_EDGE   = 3'd3;
    localparam logic [2:0] ADDR_IRQ_EN = 3'd4;

    localparam int              CNT_W      = 3;
    localparam logic [CNT_W-1:0] PRIME_INIT = CNT_W'(SYNC_STAGES + 1);

    logic [WIDTH-1:0] out_q;
    logic [WIDTH-1:0] dir_q;
    logic [WIDTH-1:0] edge_q;
    logic [WIDTH-1:0] irq_en_q;
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [CNT_W-1:0] prime_cnt;

    logic [WIDTH-1:0] sync_in;
    logic [WIDTH-1:0] rise;
    logic [WIDTH-1:0] w1c_mask;
    logic [WIDTH-1:0] edge_next;
    logic [WIDTH-1:0] irq_en_next;
    logic [WIDTH-1:0] rd_mux;

    // NOTE: every signal assigned in always_comb gets a default first so no latch is inferred.
    always_comb begin
        sync_in     = sync_q[SYNC_STAGES-1];
        rise        = '0;
        w1c_mask    = '0;
        irq_en_next = irq_en_q;
        rd_mux      = '0;

        // Edge capture stays masked until the synchroniser has flushed its reset contents.
        if (prime_cnt == '0)
            rise = sync_in & ~prev_q;
        if (i_we && i_addr == ADDR_EDGE)
            w1c_mask = i_wdata;
        if (i_we && i_addr == ADDR_IRQ_EN)
            irq_en_next = i_wdata;

        edge_next = (edge_q & ~w1c_mask) | rise;

        case (i_addr)
            ADDR_OUT:    rd_mux = out_q;
            ADDR_DIR:    rd_mux = dir_q;
            ADDR_IN:     rd_mux = sync_in;
            ADDR_EDGE:   rd_mux = edge_q;
            ADDR_IRQ_EN: rd_mux = irq_en_q;
            default:     rd_mux = '0;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            out_q     <= '0;
            dir_q     <= '0;
            edge_q    <= '0;
            irq_en_q  <= '0;
            prev_q    <= '0;
            prime_cnt <= PRIME_INIT;
            for (int i = 0; i < SYNC_STAGES; i++)
                sync_q[i] <= '0;
            o_rdata   <= '0;
            o_ack     <= 1'b0;
            o_irq     <= 1'b0;
        end else if (i_clk_en) begin
            sync_q[0] <= i_gpio;
            for (int i = 1; i < SYNC_STAGES; i++)
                sync_q[i] <= sync_q[i-1];
            prev_q <= sync_in;
            if (prime_cnt != '0)
                prime_cnt <= prime_cnt - 1'b1;

            edge_q   <= edge_next;
            irq_en_q <= irq_en_next;
            o_irq    <= |(edge_next & irq_en_next);
            o_ack    <= i_we | i_re;

            // A simultaneous read and write is handled as a write; o_rdata keeps its value.
            if (i_we) begin
                if (i_addr == ADDR_OUT) out_q <= i_wdata;
                if (i_addr == ADDR_DIR) dir_q <= i_wdata;
            end else if (i_re) begin
                o_rdata <= rd_mux;
            end
        end
    end

    assign o_gpio    = out_q;
    assign o_gpio_oe = dir_q;

endmodule
